reorder_buffer: RTL and testbench

Circular reorder buffer for the out-of-order LC-3b core. It sits directly upstream of the commit stage. Dispatch allocates an entry in program order and receives the entry's tag. Execution units complete entries out of order over the CDB by tag. The head entry is presented to commit, which retires it with `RE` or discards the whole buffer with `flush`. Depth is 2^tag_width entries.

---
 rtl/reorder_buffer.sv | 103 ++++++++++
 tb/tb_reorder_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order-retire buffer between dispatch, the CDB and commit
module reorder_buffer #(
   parameter int data_width = 16,
   parameter int tag_width  = 3
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  we,
   input  logic [3:0]            opcode_in,
   input  logic [2:0]            dest_in,
   input  logic                  predict_in,
   input  logic                  ready_in,
   input  logic [data_width-1:0] value_in,
   output logic [tag_width-1:0]  rob_tag,
   output logic                  full,
   input  logic                  cdb_valid,
   input  logic [tag_width-1:0]  cdb_tag,
   input  logic [data_width-1:0] cdb_value,
   input  logic [tag_width-1:0]  rd_tag,
   output logic                  rd_ready,
   output logic [data_width-1:0] rd_value,
   input  logic                  RE,
   input  logic                  flush,
   output logic                  valid_out,
   output logic [3:0]            opcode_out,
   output logic [2:0]            dest_out,
   output logic [data_width-1:0] value_out,
   output logic                  predict_out,
   output logic                  empty
);
   localparam int depth = 1 << tag_width;
   logic                  busy_q    [depth];
   logic                  ready_q   [depth];
   logic [3:0]            opcode_q  [depth];
   logic [2:0]            dest_q    [depth];
   logic [data_width-1:0] value_q   [depth];
   logic                  predict_q [depth];
   logic [tag_width-1:0]  head_q, head_d, tail_q, tail_d;
   logic [tag_width:0]    count_q, count_d;
   logic                  disp, ret, cdb_hit;
   assign full        = count_q == (tag_width+1)'(depth);
   assign empty       = count_q == '0;
   assign rob_tag     = tail_q;
   assign valid_out   = busy_q[head_q] & ready_q[head_q];
   assign opcode_out  = opcode_q[head_q];
   assign dest_out    = dest_q[head_q];
   assign value_out   = value_q[head_q];
   assign predict_out = predict_q[head_q];
   assign rd_ready    = busy_q[rd_tag] & ready_q[rd_tag];
   assign rd_value    = value_q[rd_tag];
   // accepted events; a CDB write to the entry retiring this cycle is dropped
   always_comb begin
      disp    = we & ~full & ~flush;
      ret     = RE & valid_out & ~flush;
      cdb_hit = cdb_valid & ~flush & busy_q[cdb_tag] & ~(ret & (cdb_tag == head_q));
      head_d  = flush ? '0 : head_q + tag_width'(ret);
      tail_d  = flush ? '0 : tail_q + tag_width'(disp);
      count_d = flush ? '0 : count_q + (tag_width+1)'(disp) - (tag_width+1)'(ret);
   end
   // pointer/count state and entry storage; flush only drops busy/ready
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < depth; i++) begin
            busy_q[i]    <= 1'b0;
            ready_q[i]   <= 1'b0;
            opcode_q[i]  <= '0;
            dest_q[i]    <= '0;
            value_q[i]   <= '0;
            predict_q[i] <= 1'b0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (flush) begin
            for (int i = 0; i < depth; i++) begin
               busy_q[i]  <= 1'b0;
               ready_q[i] <= 1'b0;
            end
         end else begin
            if (disp) begin
               busy_q[tail_q]    <= 1'b1;
               ready_q[tail_q]   <= ready_in;
               opcode_q[tail_q]  <= opcode_in;
               dest_q[tail_q]    <= dest_in;
               value_q[tail_q]   <= ready_in ? value_in : '0;
               predict_q[tail_q] <= predict_in;
            end
            if (cdb_hit) begin
               ready_q[cdb_tag] <= 1'b1;
               value_q[cdb_tag] <= cdb_value;
            end
            if (ret) begin
               busy_q[head_q]  <= 1'b0;
               ready_q[head_q] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of dispatch, CDB completion, retire, full/wrap and flush
module tb_reorder_buffer;
   logic        clk = 0, clr = 1, we = 0, predict_in = 0, ready_in = 0;
   logic [3:0]  opcode_in = 0, opcode_out;
   logic [2:0]  dest_in = 0, dest_out, rob_tag, cdb_tag = 0, rd_tag = 0;
   logic [15:0] value_in = 0, cdb_value = 0, rd_value, value_out;
   logic        full, cdb_valid = 0, rd_ready, RE = 0, flush = 0, valid_out, predict_out, empty;
   int          cmps = 0, errs = 0;
   reorder_buffer dut (
      .clk(clk), .clr(clr), .we(we), .opcode_in(opcode_in), .dest_in(dest_in),
      .predict_in(predict_in), .ready_in(ready_in), .value_in(value_in),
      .rob_tag(rob_tag), .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_value(cdb_value), .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_value(rd_value),
      .RE(RE), .flush(flush), .valid_out(valid_out), .opcode_out(opcode_out),
      .dest_out(dest_out), .value_out(value_out), .predict_out(predict_out), .empty(empty)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic dispatch(input logic [3:0] op, input logic rdy, input logic [15:0] v);
      we = 1; opcode_in = op; dest_in = 3'd5; predict_in = 1; ready_in = rdy; value_in = v;
      tick();
      we = 0; ready_in = 0; predict_in = 0;
   endtask
   initial begin
      #3;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_tag", rob_tag, 0);
      chk("rst_rdready", rd_ready, 0);
      chk("rst_fields", {opcode_out, dest_out, value_out, predict_out, rd_value}, 0);
      clr = 0;
      tick();
      // in-order retire of out-of-order completions
      chk("tag0", rob_tag, 0); dispatch(4'h1, 0, 0);
      chk("tag1", rob_tag, 1); dispatch(4'h1, 0, 0);
      chk("tag2", rob_tag, 2); dispatch(4'h1, 0, 0);
      chk("three_tag", rob_tag, 3);
      chk("three_valid", valid_out, 0);
      chk("three_empty", empty, 0);
      chk("head_op", opcode_out, 4'h1);
      chk("head_dest", dest_out, 5);
      chk("head_pred", predict_out, 1);
      cdb_valid = 1; cdb_tag = 2; cdb_value = 16'h0003; tick();
      chk("cdb2_valid", valid_out, 0);
      cdb_tag = 0; cdb_value = 16'h0001;
      chk("cdb0_nobypass", valid_out, 0);
      tick();
      chk("cdb0_valid", valid_out, 1);
      chk("cdb0_val", value_out, 16'h0001);
      cdb_tag = 1; cdb_value = 16'h0002; RE = 1; tick();
      cdb_valid = 0;
      chk("ret1_valid", valid_out, 1);
      chk("ret1_val", value_out, 16'h0002);
      tick();
      chk("ret2_val", value_out, 16'h0003);
      tick();
      RE = 0;
      chk("ret3_empty", empty, 1);
      chk("ret3_valid", valid_out, 0);
      // stale CDB to a retired tag
      cdb_valid = 1; cdb_tag = 0; cdb_value = 16'h00FF; tick(); cdb_valid = 0;
      rd_tag = 0; #1;
      chk("stale_empty", empty, 1);
      chk("stale_valid", valid_out, 0);
      chk("stale_rd", rd_ready, 0);
      // operand lookup
      chk("lea_tag", rob_tag, 3);
      dispatch(4'hE, 1, 16'h1234);
      rd_tag = 3; #1;
      chk("lea_rdready", rd_ready, 1);
      chk("lea_rdval", rd_value, 16'h1234);
      chk("lea_valid", valid_out, 1);
      chk("lea_op", opcode_out, 4'hE);
      dispatch(4'h1, 0, 16'hBEEF);
      rd_tag = 4; #1;
      chk("pend_rdready", rd_ready, 0);
      chk("pend_rdval", rd_value, 0);
      RE = 1; tick(); RE = 0;
      chk("lea_ret_valid", valid_out, 0);
      RE = 1; tick(); RE = 0;
      chk("ret_notready_ign", empty, 0);
      cdb_valid = 1; cdb_tag = 6; cdb_value = 16'h0666; tick();
      rd_tag = 6; #1;
      chk("never_valid", valid_out, 0);
      chk("never_rd", rd_ready, 0);
      cdb_tag = 4; cdb_value = 16'h0055; tick(); cdb_valid = 0;
      chk("cdb4_valid", valid_out, 1);
      chk("cdb4_val", value_out, 16'h0055);
      cdb_valid = 1; cdb_tag = 4; cdb_value = 16'h0099; RE = 1;
      chk("race_val", value_out, 16'h0055);
      tick(); cdb_valid = 0; RE = 0;
      rd_tag = 4; #1;
      chk("race_empty", empty, 1);
      chk("race_rd", rd_ready, 0);
      chk("race_tag", rob_tag, 5);
      // async reset mid-operation
      dispatch(4'h1, 1, 1); dispatch(4'h1, 1, 2); dispatch(4'h1, 1, 3);
      chk("pre_clr_tag", rob_tag, 0);
      #2 clr = 1; #1;
      chk("clr_empty", empty, 1);
      chk("clr_tag", rob_tag, 0);
      chk("clr_valid", valid_out, 0);
      #2 clr = 0;
      tick();
      // full and wrap
      for (int i = 0; i < 8; i++) dispatch(4'h1, 1, 16'h10 + 16'(i));
      chk("full", full, 1);
      chk("full_tag", rob_tag, 0);
      dispatch(4'h1, 1, 16'hDEAD);
      chk("ninth_full", full, 1);
      chk("ninth_head", value_out, 16'h10);
      RE = 1; dispatch(4'h1, 1, 16'hDEAD); RE = 0;
      chk("retfull_full", full, 0);
      chk("retfull_tag", rob_tag, 0);
      chk("retfull_head", value_out, 16'h11);
      dispatch(4'h1, 1, 16'h00AA);
      rd_tag = 0; #1;
      chk("wrap_full", full, 1);
      chk("wrap_tag", rob_tag, 1);
      chk("wrap_rd", rd_value, 16'h00AA);
      // flush priority with five live entries
      RE = 1; tick(); tick(); tick(); RE = 0;
      chk("five_head", value_out, 16'h14);
      we = 1; ready_in = 1; value_in = 16'h0BAD; cdb_valid = 1; cdb_tag = 4; RE = 1; flush = 1;
      tick();
      we = 0; ready_in = 0; cdb_valid = 0; RE = 0; flush = 0;
      chk("flush_empty", empty, 1);
      chk("flush_tag", rob_tag, 0);
      chk("flush_valid", valid_out, 0);
      chk("flush_full", full, 0);
      for (int i = 0; i < 8; i++) begin
         rd_tag = 3'(i); #1;
         chk($sformatf("flush_rd%0d", i), rd_ready, 0);
      end
      dispatch(4'h1, 1, 16'h0077);
      chk("post_flush_valid", valid_out, 1);
      chk("post_flush_val", value_out, 16'h0077);
      chk("post_flush_tag", rob_tag, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule
